yuv422_stream_packer: RTL and testbench
=======================================

# yuv422_stream_packer

Packs the 8-bit YCbCr 4:2:2 byte stream (Cb, Y0, Cr, Y1 order) leaving the camera receive block's data FIFO into 32-bit macropixel words on an AXI4-Stream master. It adds video framing for the downstream VDMA-style writer: TUSER on the first word of a frame and TLAST on the last word of each line. Line width and frame height come from rx_cfg. It runs entirely in the AXI clock domain, downstream of the camera receive block.

## Interface
- `WIDTH_BITS`, 12: width of pixel/line counters and cfg fields.
- `axi_clk_i`  in  1  AXI stream/config clock.
- `axi_rstn_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  rx_cfg.rx_enable; 0 = synchronous soft reset of FSM/counters (not of sticky errors).
- `cfg_width_i`  in  WIDTH_BITS  pixels per line; even, ≥2; sampled at SOF.
- `cfg_height_i`  in  WIDTH_BITS  lines per frame, ≥1; sampled at SOF.
- `err_clr_i`  in  1  single-cycle pulse, clears sticky errors.
- `s_tdata`  in  8  input byte.
- `s_tvalid`  in  1  input valid.
- `s_tready`  out  1  input ready.
- `s_tuser`  in  1  marks first byte (Cb0) of a frame.
- `m_tdata`  out  32  macropixel word.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  output ready.
- `m_tuser`  out  1  first word of frame.
- `m_tlast`  out  1  last word of line.
- `sof_err_o`  out  1  sticky: s_tuser seen mid-frame.
- `frame_cnt_o`  out  16  completed frames, wraps.

## Operation
- FSM states: IDLE, WAIT_SOF, ACTIVE.
- IDLE: entered on reset or enable_i=0; s_tready=1, bytes dropped. enable_i=1 → WAIT_SOF.
- WAIT_SOF: s_tready=1; bytes dropped until accepted byte has s_tuser=1. That byte is phase 0. Latch cfg_width/cfg_height. Clear counters. Go to ACTIVE.
- ACTIVE: accepted bytes fill phase 0..3 (Cb, Y0, Cr, Y1). The phase-3 byte forms the word {Y1,Cr,Y0,Cb} (Cb in [7:0]).
- Word counter runs 0..width/2−1. m_tlast=1 when the counter is width/2−1; the counter then wraps to 0 and the line counter increments.
- m_tuser=1 on word 0 of line 0 only.
- When the line counter reaches height after a TLAST: frame_cnt_o++ (16-bit wrap) and go to WAIT_SOF.
- s_tuser=1 on an accepted byte in ACTIVE: sof_err_o←1. The partial word is discarded. That byte becomes phase 0 of a new frame (same actions as WAIT_SOF exit). No TLAST is emitted for the truncated line.
- err_clr_i clears sof_err_o. If an error and err_clr_i occur in the same cycle, set wins.
- Buffering: the output register plus a 1-word skid register. s_tready = !(out_valid && skid_valid) in ACTIVE.
- Output handshake: m_tdata/m_tuser/m_tlast are held stable while m_tvalid=1 and m_tready=0. Words are never dropped or reordered.
- enable_i=0 mid-frame: flush both word slots (m_tvalid→0 next cycle, no completion) and go to IDLE. frame_cnt_o and sof_err_o are retained.

## Timing
- Reset values: all outputs 0 except s_tready=1. FSM=IDLE, phase=0, counters=0, skid empty.
- Latency: phase-3 byte accepted at cycle N → m_tvalid=1 at N+1 (when the output slot is free or draining).
- Throughput: 1 byte/cycle in, ≤1 word per 4 cycles out. Full rate is sustained with m_tready=1.
- Stall: once both slots are full, s_tready drops the next cycle. It rises the cycle after m_tvalid&&m_tready.
- When m_tready=1 with a word in skid, skid shifts to output in the same cycle and s_tready rises.
- Counters are WIDTH_BITS wide. width/2 uses cfg_width_i[WIDTH_BITS−1:1]. Odd width is truncated.

## Configuration
- `YUV_PACKER_SWAP_EN` defined: output byte order is {Cb,Y0,Cr,Y1} (Cb in [31:24]) for big-endian consumers.
- Undefined: {Y1,Cr,Y0,Cb`}` as specified above.
- No other behaviour changes.

## Test plan
- Reset, then width=4, height=2, bytes 0x10..0x1F with tuser on 0x10, m_tready=1 → 4 words: 0x13121110 (tuser), 0x17161514 (tlast), 0x1B1A1918, 0x1F1E1D1C (tlast); frame_cnt_o=1.
- Bytes before the first tuser (0xAA×5), then a valid frame → no output for 0xAA bytes; the first output word carries tuser.
- Same frame as test 1 with m_tready=0 for 20 cycles → s_tready falls after 2 buffered words. Data is held stable. After release, all 4 words arrive exactly once, in order.
- tuser asserted on the 3rd byte of line 0 → sof_err_o=1, partial word dropped, new frame starts from that byte. err_clr_i pulse → sof_err_o=0.
- enable_i=0 for 1 cycle mid-line → m_tvalid=0 next cycle, FSM in IDLE, frame_cnt_o unchanged. A next frame with tuser packs correctly.
- Compile with `YUV_PACKER_SWAP_EN`, rerun test 1 → first word 0x10111213.

Source files
------------

// File: rtl/yuv422_stream_packer_if.sv
// Byte-in / macropixel-out stream bundle for the YCbCr 4:2:2 packer.
// master = packer side, slave = source/sink environment side.
interface yuv422_stream_packer_if;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tuser;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;

  modport master (
    input  s_tdata, s_tvalid, s_tuser, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );

  modport slave (
    output s_tdata, s_tvalid, s_tuser, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/yuv422_stream_packer.sv
// Packs Cb,Y0,Cr,Y1 bytes into 32-bit AXI4-Stream words with TUSER/TLAST video framing.
// Optional define YUV_PACKER_SWAP_EN: big-endian word order {Cb,Y0,Cr,Y1}.
module yuv422_stream_packer #(
  parameter int unsigned WIDTH_BITS = 12
) (
  input  logic                   axi_clk_i,
  input  logic                   axi_rstn_i,
  input  logic                   enable_i,
  input  logic [WIDTH_BITS-1:0]  cfg_width_i,
  input  logic [WIDTH_BITS-1:0]  cfg_height_i,
  input  logic                   err_clr_i,
  yuv422_stream_packer_if.master bus,
  output logic                   sof_err_o,
  output logic [15:0]            frame_cnt_o
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [WORD_W-1:0] data;
  } word_t;

  state_t                  r_state, w_state_nxt;
  logic [PHASE_W-1:0]      r_phase, w_phase_nxt;
  logic [2:0][BYTE_W-1:0]  r_bytes, w_bytes_nxt;
  logic [WIDTH_BITS-1:0]   r_half_w, w_half_w_nxt;
  logic [WIDTH_BITS-1:0]   r_height, w_height_nxt;
  logic [WIDTH_BITS-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic [WIDTH_BITS-1:0]   r_line_cnt, w_line_cnt_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic                    r_skid_valid, w_skid_valid_nxt;
  word_t                   r_out, w_out_nxt;
  word_t                   r_skid, w_skid_nxt;
  word_t                   w_word;
  logic                    r_sof_err, w_sof_err_nxt;
  logic [FCNT_W-1:0]       r_frame_cnt, w_frame_cnt_nxt;
  logic                    w_s_tready, w_acc, w_pop, w_push, w_start, w_sof_set;

  // Input is only back-pressured while packing and both word slots are occupied.
  assign w_s_tready = (r_state == ACTIVE) ? !(r_out_valid && r_skid_valid) : 1'b1;
  assign w_acc      = bus.s_tvalid && w_s_tready;
  assign w_pop      = r_out_valid && bus.m_tready;

  // Candidate word, completed by the byte arriving in phase 3.
  always_comb begin
    w_word.tuser = (r_word_cnt == '0) && (r_line_cnt == '0);
    w_word.tlast = (r_word_cnt == (r_half_w - WIDTH_BITS'(1)));
`ifdef YUV_PACKER_SWAP_EN
    w_word.data  = {r_bytes[0], r_bytes[1], r_bytes[2], bus.s_tdata};
`else
    w_word.data  = {bus.s_tdata, r_bytes[2], r_bytes[1], r_bytes[0]};
`endif
  end

  // Next-state, counters and two-slot output buffer.
  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_bytes_nxt      = r_bytes;
    w_half_w_nxt     = r_half_w;
    w_height_nxt     = r_height;
    w_word_cnt_nxt   = r_word_cnt;
    w_line_cnt_nxt   = r_line_cnt;
    w_out_valid_nxt  = r_out_valid;
    w_out_nxt        = r_out;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_nxt       = r_skid;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_push           = 1'b0;
    w_start          = 1'b0;
    w_sof_set        = 1'b0;

    if (!enable_i) begin
      w_state_nxt      = IDLE;
      w_phase_nxt      = '0;
      w_word_cnt_nxt   = '0;
      w_line_cnt_nxt   = '0;
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = WAIT_SOF;
        WAIT_SOF: begin
          if (w_acc && bus.s_tuser) w_start = 1'b1;
        end
        ACTIVE: begin
          if (w_acc) begin
            if (bus.s_tuser) begin
              w_start   = 1'b1;
              w_sof_set = 1'b1;
            end else if (r_phase != PHASE_W'(3)) begin
              w_bytes_nxt[r_phase] = bus.s_tdata;
              w_phase_nxt          = r_phase + PHASE_W'(1);
            end else begin
              w_push      = 1'b1;
              w_phase_nxt = '0;
              if (w_word.tlast) begin
                w_word_cnt_nxt = '0;
                w_line_cnt_nxt = r_line_cnt + WIDTH_BITS'(1);
                if ((r_line_cnt + WIDTH_BITS'(1)) == r_height) begin
                  w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
                  w_state_nxt     = WAIT_SOF;
                end
              end else begin
                w_word_cnt_nxt = r_word_cnt + WIDTH_BITS'(1);
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      // Frame start: this byte is Cb of word 0, line 0.
      if (w_start) begin
        w_state_nxt    = ACTIVE;
        w_bytes_nxt[0] = bus.s_tdata;
        w_phase_nxt    = PHASE_W'(1);
        w_half_w_nxt   = WIDTH_BITS'(cfg_width_i >> 1);
        w_height_nxt   = cfg_height_i;
        w_word_cnt_nxt = '0;
        w_line_cnt_nxt = '0;
      end

      if (w_pop) begin
        if (r_skid_valid) begin
          w_out_nxt        = r_skid;
          w_out_valid_nxt  = 1'b1;
          w_skid_valid_nxt = w_push;
          w_skid_nxt       = w_word;
        end else begin
          w_out_valid_nxt  = w_push;
          w_out_nxt        = w_word;
        end
      end else if (!r_out_valid) begin
        w_out_valid_nxt = w_push;
        if (w_push) w_out_nxt = w_word;
      end else if (w_push) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_nxt       = w_word;
      end
    end

    if (w_sof_set)      w_sof_err_nxt = 1'b1;
    else if (err_clr_i) w_sof_err_nxt = 1'b0;
    else                w_sof_err_nxt = r_sof_err;
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_bytes      <= '0;
      r_half_w     <= '0;
      r_height     <= '0;
      r_word_cnt   <= '0;
      r_line_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_sof_err    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_bytes      <= w_bytes_nxt;
      r_half_w     <= w_half_w_nxt;
      r_height     <= w_height_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_line_cnt   <= w_line_cnt_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out        <= w_out_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_sof_err    <= w_sof_err_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign bus.s_tready = w_s_tready;
  assign bus.m_tdata  = r_out.data;
  assign bus.m_tvalid = r_out_valid;
  assign bus.m_tuser  = r_out.tuser;
  assign bus.m_tlast  = r_out.tlast;
  assign sof_err_o    = r_sof_err;
  assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_yuv422_stream_packer.sv
// Self-checking bench for yuv422_stream_packer: table vectors, corner sequences, random frames.
module tb_yuv422_stream_packer;

  localparam int unsigned WB = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } obs_t;
  typedef struct {
    logic [31:0] in_bytes;
    logic [31:0] exp_data;
    logic        exp_user;
    logic        exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [WB-1:0] cfg_w, cfg_h;
  logic          err_clr;
  logic          sof_err;
  logic [15:0]   frame_cnt;

  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;
  int   exp_frames = 0;
  obs_t got_q[$];
  obs_t exp_q[$];
  bit   mon_prev_stall = 1'b0;
  obs_t mon_prev;

  yuv422_stream_packer_if u_if();

  yuv422_stream_packer #(.WIDTH_BITS(WB)) dut (
    .axi_clk_i   (clk),
    .axi_rstn_i  (rst_n),
    .enable_i    (enable),
    .cfg_width_i (cfg_w),
    .cfg_height_i(cfg_h),
    .err_clr_i   (err_clr),
    .bus         (u_if.master),
    .sof_err_o   (sof_err),
    .frame_cnt_o (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] cb, y0, cr, y1);
`ifdef YUV_PACKER_SWAP_EN
    return {cb, y0, cr, y1};
`else
    return {y1, cr, y0, cb};
`endif
  endfunction

  // Reference: word k of a frame is bytes 4k..4k+3; TUSER on word 0, TLAST every width/2 words.
  function automatic void build_exp(input bq_t b, input int w);
    int   half;
    obs_t o;
    half = w / 2;
    for (int k = 0; k < b.size() / 4; k++) begin
      o.data = pack4(b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]);
      o.user = (k == 0);
      o.last = ((k % half) == (half - 1));
      exp_q.push_back(o);
    end
  endfunction

  function automatic bq_t make_frame(input int w, input int h);
    bq_t b;
    for (int i = 0; i < (w / 2) * 4 * h; i++) b.push_back(8'($urandom_range(0, 255)));
    return b;
  endfunction

  // Output ready pattern, updated just after each rising edge.
  initial begin
    u_if.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       u_if.m_tready = 1'b1;
        1:       u_if.m_tready = ($urandom_range(0, 3) != 0);
        default: u_if.m_tready = 1'b0;
      endcase
    end
  end

  // Collects accepted words and checks they stay put while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mon_prev_stall) begin
          chk("hold_valid", 32'(u_if.m_tvalid), 32'd1);
          chk("hold_data", u_if.m_tdata, mon_prev.data);
          chk("hold_flags", 32'({u_if.m_tuser, u_if.m_tlast}), 32'({mon_prev.user, mon_prev.last}));
        end
        if (u_if.m_tvalid && u_if.m_tready)
          got_q.push_back({u_if.m_tuser, u_if.m_tlast, u_if.m_tdata});
        mon_prev_stall = u_if.m_tvalid && !u_if.m_tready && enable;
        mon_prev       = {u_if.m_tuser, u_if.m_tlast, u_if.m_tdata};
      end else begin
        mon_prev_stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the byte's accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic u, input bit gaps);
    int  n;
    logic acc;
    if (gaps) begin
      u_if.s_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    u_if.s_tdata  = d;
    u_if.s_tuser  = u;
    u_if.s_tvalid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n <= 300) begin
      @(negedge clk);
      acc = u_if.s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte 0x%02h not accepted", d);
    end
    u_if.s_tvalid = 1'b0;
    u_if.s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input bq_t b, input bit gaps, input bit scramble);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], (i == 0), gaps);
      if (scramble && i == 0) begin
        cfg_w = WB'($urandom);
        cfg_h = WB'($urandom);
      end
    end
  endtask

  task automatic wait_words(input int cnt);
    int n;
    n = 0;
    while (got_q.size() < cnt && n < 2000) begin @(posedge clk); n++; end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string name);
    wait_words(exp_q.size());
    chk({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({name, "_data"}, got_q[i].data, exp_q[i].data);
      chk({name, "_flags"}, 32'({got_q[i].user, got_q[i].last}), 32'({exp_q[i].user, exp_q[i].last}));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[4];
    bq_t  fb;
    int   w, h;

    vecs[0] = '{32'h10111213, 32'h13121110, 1'b1, 1'b0};
    vecs[1] = '{32'h14151617, 32'h17161514, 1'b0, 1'b1};
    vecs[2] = '{32'h18191A1B, 32'h1B1A1918, 1'b0, 1'b0};
    vecs[3] = '{32'h1C1D1E1F, 32'h1F1E1D1C, 1'b0, 1'b1};
`ifdef YUV_PACKER_SWAP_EN
    vecs[0].exp_data = 32'h10111213;
    vecs[1].exp_data = 32'h14151617;
    vecs[2].exp_data = 32'h18191A1B;
    vecs[3].exp_data = 32'h1C1D1E1F;
`endif

    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0;
    cfg_w = WB'(4); cfg_h = WB'(2);
    u_if.s_tdata = 8'h00; u_if.s_tvalid = 1'b0; u_if.s_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(u_if.m_tvalid), 32'd0);
    chk("rst_tdata", u_if.m_tdata, 32'd0);
    chk("rst_tflags", 32'({u_if.m_tuser, u_if.m_tlast}), 32'd0);
    chk("rst_s_tready", 32'(u_if.s_tready), 32'd1);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    enable = 1'b1;
    cycles(2);

    // Table-driven frame: width 4, height 2, bytes 0x10..0x1F.
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(vecs[v].in_bytes[31-8*j -: 8], (v == 0 && j == 0), 1'b0);
        if (v == 0 && j == 3) chk("latency_tvalid", 32'(u_if.m_tvalid), 32'd1);
      end
    end
    wait_words(4);
    chk("t1_nwords", 32'(got_q.size()), 32'd4);
    for (int v = 0; v < 4; v++) begin
      if (v < got_q.size()) begin
        chk("t1_data", got_q[v].data, vecs[v].exp_data);
        chk("t1_flags", 32'({got_q[v].user, got_q[v].last}), 32'({vecs[v].exp_user, vecs[v].exp_last}));
      end
    end
    got_q.delete();
    exp_frames++;
    chk("t1_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Junk bytes before the start-of-frame must vanish.
    cfg_w = WB'(4); cfg_h = WB'(1);
    for (int i = 0; i < 5; i++) send_byte(8'hAA, 1'b0, 1'b0);
    fb = make_frame(4, 1);
    build_exp(fb, 4);
    send_frame(fb, 1'b0, 1'b0);
    compare_all("t2");
    exp_frames++;
    chk("t2_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Backpressure: hold m_tready low while the frame streams in.
    cfg_w = WB'(4); cfg_h = WB'(2);
    rdy_mode = 2;
    cycles(1);
    fb.delete();
    for (int i = 0; i < 16; i++) fb.push_back(8'(8'h10 + i));
    build_exp(fb, 4);
    fork
      send_frame(fb, 1'b0, 1'b0);
    join_none
    cycles(20);
    chk("t3_s_tready_low", 32'(u_if.s_tready), 32'd0);
    chk("t3_tvalid_held", 32'(u_if.m_tvalid), 32'd1);
    chk("t3_tdata_held", u_if.m_tdata, vecs[0].exp_data);
    chk("t3_no_words", 32'(got_q.size()), 32'd0);
    rdy_mode = 0;
    wait fork;
    compare_all("t3");
    exp_frames++;
    chk("t3_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Start-of-frame inside a frame restarts packing from that byte.
    cfg_w = WB'(4); cfg_h = WB'(1);
    send_byte(8'h20, 1'b1, 1'b0);
    send_byte(8'h21, 1'b0, 1'b0);
    chk("t4_err_before", 32'(sof_err), 32'd0);
    send_byte(8'h30, 1'b1, 1'b0);
    chk("t4_err_set", 32'(sof_err), 32'd1);
    for (int i = 1; i < 8; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0);
    fb.delete();
    for (int i = 0; i < 8; i++) fb.push_back(8'(8'h30 + i));
    build_exp(fb, 4);
    compare_all("t4");
    exp_frames++;
    chk("t4_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(sof_err), 32'd0);

    // Error set and clear in the same cycle: set wins.
    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h41, 1'b0, 1'b0);
    err_clr = 1'b1;
    send_byte(8'h50, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(sof_err), 32'd1);
    fb.delete();
    fb.push_back(8'h50);
    for (int i = 1; i < 8; i++) begin
      fb.push_back(8'(8'h50 + i));
      send_byte(8'(8'h50 + i), 1'b0, 1'b0);
    end
    build_exp(fb, 4);
    compare_all("t4b");
    exp_frames++;
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;

    // Disable mid-line with a word waiting: flushed, no completion.
    cfg_w = WB'(4); cfg_h = WB'(2);
    rdy_mode = 2;
    cycles(1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i), (i == 0), 1'b0);
    chk("t5_word_pending", 32'(u_if.m_tvalid), 32'd1);
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    chk("t5_tvalid_flushed", 32'(u_if.m_tvalid), 32'd0);
    chk("t5_s_tready", 32'(u_if.s_tready), 32'd1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    rdy_mode = 0;
    cycles(3);
    chk("t5_no_stale", 32'(got_q.size()), 32'd0);
    fb = make_frame(4, 2);
    build_exp(fb, 4);
    send_frame(fb, 1'b0, 1'b0);
    compare_all("t5");
    exp_frames++;
    chk("t5_frame_cnt_after", 32'(frame_cnt), 32'(exp_frames));

    // Random frames, random gaps/backpressure, cfg changed after SOF.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      w = (f == 0) ? 2 : ((f == 1) ? 5 : $urandom_range(2, 17));
      h = $urandom_range(1, 4);
      cfg_w = WB'(w);
      cfg_h = WB'(h);
      fb = make_frame(w, h);
      build_exp(fb, w);
      send_frame(fb, 1'b1, 1'b1);
      compare_all("rnd");
      exp_frames++;
      chk("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    end
    chk("final_sof_err", 32'(sof_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
